digit_counter_bank: RTL and testbench
=====================================

DIGIT_COUNTER_BANK -- requirements
Module: digit_counter_bank

Interface
REQ-001 The block SHALL be clocked on the rising edge of one clock; reset is synchronous and active-low.
REQ-002 Parameter DIGITS, default 4, SHALL set the number of 4-bit digit channels (legal 1..8).
REQ-003 Parameter RADIX, default 16, SHALL set the per-digit modulus (legal 2..16).
REQ-004 Parameter DB_CYCLES, default 16'd50000, SHALL set the debounce stability window in clocks (legal 1..65535).
REQ-005 Parameter INIT, width 4*DIGITS, default 16'h0010, SHALL set the reset value of num.
REQ-006 clk  input  1  system clock.
REQ-007 rst_n  input  1  synchronous active-low reset.
REQ-008 sw  input  DIGITS  raw asynchronous switch/button levels, one per digit.
REQ-009 dir  input  1  count direction: 0 = up, 1 = down.
REQ-010 carry_en  input  1  1 = wrap of digit i carries/borrows into digit i+1 in the same cycle.
REQ-011 load  input  1  synchronous parallel load strobe.
REQ-012 load_val  input  4*DIGITS  value written on load.
REQ-013 num  output  4*DIGITS  digit register; digit i occupies bits [4i+3:4i].
REQ-014 step  output  DIGITS  one-cycle pulse per accepted press, for observation.
REQ-015 ovf  output  1  one-cycle pulse when the top digit wraps.

Function
REQ-016 Each sw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-017 Each channel's debouncer SHALL have states STABLE and PENDING.
REQ-018 In STABLE, a synchronized level different from the accepted level SHALL move the debouncer to PENDING and clear its counter.
REQ-019 In PENDING, the counter SHALL increment while the new level persists.
REQ-020 When the counter reaches DB_CYCLES-1, the debouncer SHALL accept the new level and return to STABLE.
REQ-021 If the level reverts to the accepted level while PENDING, the debouncer SHALL return to STABLE with no acceptance.
REQ-022 A 0->1 acceptance SHALL assert step[i] for exactly one clock; a 1->0 acceptance SHALL produce no pulse.
REQ-023 Latency from a clean sw rising edge to the step pulse SHALL be 2 + DB_CYCLES clocks, with num updated on the clock edge that ends the step pulse.
REQ-024 Per cycle, digit i SHALL advance by a(i) = step[i] + cin(i) (0, 1 or 2) in direction dir.
REQ-025 cin(0) = 0; cin(i+1) SHALL be 1 only when carry_en = 1 and digit i wraps in this cycle.
REQ-026 The carry ripple SHALL be combinational within the cycle.
REQ-027 Up-count wrap: sum >= RADIX SHALL store sum - RADIX and flag a wrap.
REQ-028 Down-count wrap: value - a(i) < 0 SHALL store value - a(i) + RADIX and flag a wrap.
REQ-029 ovf SHALL pulse for one cycle when the top digit wraps, whether the wrap comes from its own step or from a carry.
REQ-030 With carry_en = 0, wraps SHALL NOT propagate and ovf SHALL follow the top digit's own wrap only.
REQ-031 load SHALL have priority over all steps and carries: num <= load_val and ovf = 0 that cycle; step pulses SHALL still be emitted.
REQ-032 A loaded digit value >= RADIX SHALL be held unchanged until the digit is next stepped, then treated as RADIX-1 (up: wrap to 0; down: becomes RADIX-2).
REQ-033 dir SHALL be sampled in the same cycle as the step it applies to; a mid-press change of dir SHALL NOT affect a pulse already emitted.

Reset
REQ-034 While rst_n = 0 at a clk edge, num SHALL become INIT and step and ovf SHALL become 0.
REQ-035 While rst_n = 0 at a clk edge, every debouncer SHALL enter STABLE with its accepted level set to the current synchronized sw and its counter at 0.
REQ-036 Reset mid-PENDING SHALL discard the pending press, and a switch already held high SHALL NOT produce a step after reset release.
REQ-037 Synchronizer flops SHALL NOT be reset.

Structure
REQ-038 DIR_UP/DIR_DOWN codes and the default RADIX, DB_CYCLES and INIT values SHALL live in the shared package digit_pkg.
REQ-039 One sub-module, sw_debounce (synchronizer + STABLE/PENDING FSM + edge pulse), SHALL be instantiated DIGITS times by a generate loop.
REQ-040 The digit/carry arithmetic SHALL be inline in digit_counter_bank with no clock other than clk and no derived clocks.

Verification (DB_CYCLES=4, DIGITS=4, RADIX=16, INIT=16'h0010)
REQ-041 Release reset, pulse sw[0] high for 10 clocks -> exactly one step[0] pulse 6 clocks after the edge; num=16'h0011; ovf=0.
REQ-042 Toggle sw[1] with 2-clock glitches -> no step pulse; num unchanged.
REQ-043 carry_en=1, dir=0, load 16'hFFFF, press sw[0] -> num=16'h0000 and ovf pulses once in the same cycle as the num update.
REQ-044 carry_en=0, dir=1, num=16'h0010, press sw[0] -> num=16'h001F; ovf=0.
REQ-045 carry_en=1, RADIX=10, num=16'h0009, press sw[0] and sw[1] so both step pulses land in the same cycle -> digit1 advances by 2, num=16'h0020.
REQ-046 Assert rst_n=0 while sw[2] is in PENDING and keep sw[2] high after release -> num=INIT, no step[2] until sw[2] falls and rises again.

Source files
------------

// File: rtl/digit_pkg.sv
// Shared codes and defaults for the debounced digit counter bank.
// Holds count direction codes, parameter defaults and the debouncer state type.
package digit_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int          RADIX_DEF     = 16;
  localparam logic [15:0] DB_CYCLES_DEF = 16'd50000;
  localparam logic [15:0] INIT_DEF      = 16'h0010;

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } db_state_e;

endpackage

// File: rtl/sw_debounce.sv
// One switch channel: 2-flop synchronizer, STABLE/PENDING debouncer, rise pulse.
// Ports: clk, rst_n (sync, active-low), sw (raw level), pulse (1-clk on accepted 0->1).
module sw_debounce
  import digit_pkg::*;
#(
  parameter logic [15:0] DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic pulse
);

  logic s1;
  logic s2;

  // Synchronizer stays out of reset so reset can seed the accepted level.
  always_ff @(posedge clk) begin
    s1 <= sw;
    s2 <= s1;
  end

  db_state_e   st_q;
  db_state_e   st_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic        acc_q;
  logic        acc_d;
  logic        pulse_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= ST_STABLE;
      cnt_q <= '0;
      acc_q <= s2;
      pulse <= 1'b0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      pulse <= pulse_d;
    end
  end

  always_comb begin
    st_d    = st_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    pulse_d = 1'b0;
    unique case (st_q)
      ST_STABLE: begin
        if (s2 != acc_q) begin
          st_d  = ST_PENDING;
          cnt_d = '0;
        end
      end
      ST_PENDING: begin
        if (s2 == acc_q) begin
          st_d  = ST_STABLE;
          cnt_d = '0;
        end else if (cnt_q == DB_CYCLES - 16'd1) begin
          st_d    = ST_STABLE;
          cnt_d   = '0;
          acc_d   = s2;
          pulse_d = s2;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        st_d  = ST_STABLE;
        cnt_d = '0;
      end
    endcase
  end

endmodule

// File: rtl/digit_counter_bank.sv
// Bank of debounced button-driven digits with optional carry ripple and load.
// Ports: clk, rst_n, sw, dir, carry_en, load, load_val -> num, step, ovf.
module digit_counter_bank
  import digit_pkg::*;
#(
  parameter int                  DIGITS    = 4,
  parameter int                  RADIX     = RADIX_DEF,
  parameter logic [15:0]         DB_CYCLES = DB_CYCLES_DEF,
  parameter logic [4*DIGITS-1:0] INIT      = INIT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     sw,
  input  logic                  dir,
  input  logic                  carry_en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   num,
  output logic [DIGITS-1:0]     step,
  output logic                  ovf
);

  localparam logic [4:0] R    = 5'(RADIX);
  localparam logic [4:0] RMAX = 5'(RADIX - 1);

  for (genvar g = 0; g < DIGITS; g++) begin : g_db
    sw_debounce #(
      .DB_CYCLES(DB_CYCLES)
    ) u_db (
      .clk  (clk),
      .rst_n(rst_n),
      .sw   (sw[g]),
      .pulse(step[g])
    );
  end

  logic [4*DIGITS-1:0] num_d;
  logic                top_wrap;

  // Carry ripples low to high inside one cycle; a digit can move by 2
  // when its own step and an incoming carry coincide.
  always_comb begin
    logic [4:0] v;
    logic [4:0] a;
    logic [4:0] s;
    logic       c;
    logic       w;
    v        = '0;
    a        = '0;
    s        = '0;
    c        = 1'b0;
    w        = 1'b0;
    num_d    = num;
    top_wrap = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      v = {1'b0, num[4*i +: 4]};
      a = {4'b0, step[i]} + {4'b0, c};
      w = 1'b0;
      if (a != 5'd0) begin
        // Out-of-range loaded digits behave as RADIX-1 once moved.
        if (v >= R) v = RMAX;
        if (dir == DIR_UP) begin
          s = v + a;
          if (s >= R) begin
            s = s - R;
            w = 1'b1;
          end
        end else begin
          if (v < a) begin
            s = v + R - a;
            w = 1'b1;
          end else begin
            s = v - a;
          end
        end
        num_d[4*i +: 4] = s[3:0];
      end
      if (i == DIGITS - 1) top_wrap = w;
      c = carry_en & w;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      num <= INIT;
      ovf <= 1'b0;
    end else if (load) begin
      num <= load_val;
      ovf <= 1'b0;
    end else begin
      num <= num_d;
      ovf <= top_wrap;
    end
  end

endmodule

// File: tb/tb_digit_counter_bank.sv
// Self-checking bench: radix-16 and radix-10 banks driven in parallel.
// Expected values come from integer arithmetic on the whole digit number.
module tb_digit_counter_bank;

  localparam int          DBI  = 4;
  localparam logic [15:0] DB   = 16'd4;
  localparam logic [15:0] INIT = 16'h0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sw = '0;
  logic        dir = 1'b0;
  logic        carry_en = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_val = '0;
  logic [15:0] num16, num10;
  logic [3:0]  step16, step10;
  logic        ovf16, ovf10;

  int n_chk = 0;
  int n_fail = 0;
  logic [15:0] m16, m10;

  always #5 clk = ~clk;

  digit_counter_bank #(
    .DIGITS(4), .RADIX(16), .DB_CYCLES(DB), .INIT(INIT)
  ) dut16 (
    .clk(clk), .rst_n(rst_n), .sw(sw), .dir(dir),
    .carry_en(carry_en), .load(load), .load_val(load_val),
    .num(num16), .step(step16), .ovf(ovf16)
  );

  digit_counter_bank #(
    .DIGITS(4), .RADIX(10), .DB_CYCLES(DB), .INIT(INIT)
  ) dut10 (
    .clk(clk), .rst_n(rst_n), .sw(sw), .dir(dir),
    .carry_en(carry_en), .load(load), .load_val(load_val),
    .num(num10), .step(step10), .ovf(ovf10)
  );

  function automatic void model(
    input  logic [15:0] cur,
    input  logic [3:0]  m,
    input  logic        d,
    input  logic        ce,
    input  int          r,
    output logic [15:0] nxt,
    output logic        ov
  );
    int val, w, p, t;
    ov  = 1'b0;
    nxt = cur;
    if (ce) begin
      val = 0;
      w = 0;
      p = 1;
      for (int i = 0; i < 4; i++) begin
        val += int'(cur[4*i +: 4]) * p;
        w   += int'(m[i]) * p;
        p   *= r;
      end
      t = d ? val - w : val + w;
      if (t < 0) begin
        t += p;
        ov = 1'b1;
      end else if (t >= p) begin
        t -= p;
        ov = 1'b1;
      end
      p = 1;
      for (int i = 0; i < 4; i++) begin
        nxt[4*i +: 4] = 4'((t / p) % r);
        p *= r;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        t = int'(cur[4*i +: 4]) + (d ? -int'(m[i]) : int'(m[i]));
        if (t < 0 || t >= r) begin
          t = (t + r) % r;
          if (i == 3) ov = 1'b1;
        end
        nxt[4*i +: 4] = 4'(t);
      end
    end
  endfunction

  task automatic do_load(input logic [15:0] v);
    load = 1'b1;
    load_val = v;
    @(posedge clk); #1;
    load = 1'b0;
    n_chk++;
    if (num16 !== v || num10 !== v) begin
      n_fail++;
      $display("FAIL load: num16=%h num10=%h want %h", num16, num10, v);
    end
    m16 = v;
    m10 = v;
  endtask

  task automatic press(
    input logic [3:0]  m,
    input logic        fd,
    input logic        fce,
    input logic        ld,
    input logic [15:0] lv,
    input logic        ov_en,
    input logic [15:0] x16,
    input logic [15:0] x10,
    input logic        xo16,
    input logic        xo10
  );
    logic [15:0] e16, e10, w16, w10;
    logic        o16, o10, wo16, wo10;
    logic [3:0]  ws;
    model(m16, m, fd, fce, 16, e16, o16);
    model(m10, m, fd, fce, 10, e10, o10);
    if (ov_en) begin
      e16 = x16; e10 = x10; o16 = xo16; o10 = xo10;
    end
    if (ld) begin
      e16 = lv; e10 = lv; o16 = 1'b0; o10 = 1'b0;
    end
    sw = sw | m;
    for (int k = 1; k <= 2 * DBI + 14; k++) begin
      @(posedge clk); #1;
      ws   = (k == DBI + 3) ? m : 4'h0;
      w16  = (k >= DBI + 4) ? e16 : m16;
      w10  = (k >= DBI + 4) ? e10 : m10;
      wo16 = (k == DBI + 4) ? o16 : 1'b0;
      wo10 = (k == DBI + 4) ? o10 : 1'b0;
      n_chk++;
      if (step16 !== ws || step10 !== ws) begin
        n_fail++;
        $display("FAIL press_step k=%0d: %b/%b want %b", k, step16, step10, ws);
      end
      n_chk++;
      if (num16 !== w16 || num10 !== w10) begin
        n_fail++;
        $display("FAIL press_num k=%0d: %h/%h want %h/%h",
                 k, num16, num10, w16, w10);
      end
      n_chk++;
      if (ovf16 !== wo16 || ovf10 !== wo10) begin
        n_fail++;
        $display("FAIL press_ovf k=%0d: %b/%b want %b/%b",
                 k, ovf16, ovf10, wo16, wo10);
      end
      if (k == DBI + 3) begin
        dir = fd;
        carry_en = fce;
        load = ld;
        load_val = lv;
      end else begin
        dir = 1'($urandom);
        load = 1'b0;
      end
      if (k == DBI + 6) sw = sw & ~m;
    end
    m16 = e16;
    m10 = e10;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    sw = '0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (num16 !== INIT || num10 !== INIT) begin
      n_fail++;
      $display("FAIL reset_num: %h/%h want %h", num16, num10, INIT);
    end
    n_chk++;
    if (step16 !== 4'h0 || step10 !== 4'h0 || ovf16 !== 1'b0 || ovf10 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: step %b/%b ovf %b/%b want 0",
               step16, step10, ovf16, ovf10);
    end
    rst_n = 1'b1;
    m16 = INIT;
    m10 = INIT;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_single_press;
    press(4'b0001, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    n_chk++;
    if (num16 !== 16'h0011 || num10 !== 16'h0011) begin
      n_fail++;
      $display("FAIL single_press: %h/%h want 0011", num16, num10);
    end
  endtask

  task automatic test_glitch;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        sw[1] = (k < 2);
        @(posedge clk); #1;
        n_chk++;
        if (step16 !== 4'h0 || step10 !== 4'h0 || num16 !== m16 || num10 !== m10) begin
          n_fail++;
          $display("FAIL glitch: step %b/%b num %h/%h want 0 %h/%h",
                   step16, step10, num16, num10, m16, m10);
        end
      end
    end
    repeat (10) @(posedge clk);
    #1;
    n_chk++;
    if (num16 !== m16 || num10 !== m10) begin
      n_fail++;
      $display("FAIL glitch_end: %h/%h want %h/%h", num16, num10, m16, m10);
    end
  endtask

  task automatic test_carry_ovf;
    do_load(16'hFFFF);
    press(4'b0001, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h0000, 16'h0000, 1'b1, 1'b1);
  endtask

  task automatic test_down_no_carry;
    do_load(16'h0010);
    press(4'b0001, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    n_chk++;
    if (num16 !== 16'h001F || num10 !== 16'h0019) begin
      n_fail++;
      $display("FAIL down_no_carry: %h/%h want 001f/0019", num16, num10);
    end
  endtask

  task automatic test_double_step;
    do_load(16'h0009);
    press(4'b0011, 1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    n_chk++;
    if (num10 !== 16'h0020 || num16 !== 16'h001A) begin
      n_fail++;
      $display("FAIL double_step: %h/%h want 001a/0020", num16, num10);
    end
  endtask

  task automatic test_load_priority;
    do_load(16'h0000);
    press(4'b1000, 1'b1, 1'b0, 1'b1, 16'h0456, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_oversize;
    do_load(16'h000C);
    press(4'b0001, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h000D, 16'h0000, 1'b0, 1'b0);
    do_load(16'h000C);
    press(4'b0001, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 16'h000B, 16'h0008, 1'b0, 1'b0);
    do_load(16'h00C0);
    press(4'b0001, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h00C1, 16'h00C1, 1'b0, 1'b0);
    do_load(16'h00C9);
    press(4'b0001, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h00CA, 16'h0100, 1'b0, 1'b0);
  endtask

  task automatic test_reset_pending;
    do_load(16'h0321);
    sw[2] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m16 = INIT;
    m10 = INIT;
    for (int k = 0; k < 15; k++) begin
      @(posedge clk); #1;
      n_chk++;
      if (step16 !== 4'h0 || step10 !== 4'h0 || num16 !== INIT || num10 !== INIT) begin
        n_fail++;
        $display("FAIL reset_pending k=%0d: step %b/%b num %h/%h",
                 k, step16, step10, num16, num10);
      end
    end
    sw[2] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      n_chk++;
      if (step16 !== 4'h0 || step10 !== 4'h0) begin
        n_fail++;
        $display("FAIL release_pulse k=%0d: %b/%b want 0", k, step16, step10);
      end
    end
    press(4'b0100, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic test_random;
    logic [15:0] lv;
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 4; i++) lv[4*i +: 4] = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 4) == 0) do_load(lv);
      for (int i = 0; i < 4; i++) lv[4*i +: 4] = 4'($urandom_range(0, 9));
      press(4'($urandom_range(1, 15)), 1'($urandom), 1'($urandom),
            $urandom_range(0, 7) == 0, lv,
            1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    #1;
    test_reset;
    test_single_press;
    test_glitch;
    test_carry_ovf;
    test_down_no_carry;
    test_double_step;
    test_load_priority;
    test_oversize;
    test_reset_pending;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", n_chk, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
